// File: rtl/noc_pkg.sv
// Shared NoC definitions for the router output stage.
//  - one-hot direction codes and their bit indices (index 4..0 = L,R,U,D,PE)
//  - default flit width, input count, grant counter width
//  - output-register state encoding
//  - small one-hot helper functions used by the arbiter and the port
package noc_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int NUM_IN         = 5;
    localparam int GCNT_W         = 16;

    localparam logic [4:0] DIR_L  = 5'b10000;
    localparam logic [4:0] DIR_R  = 5'b01000;
    localparam logic [4:0] DIR_U  = 5'b00100;
    localparam logic [4:0] DIR_D  = 5'b00010;
    localparam logic [4:0] DIR_PE = 5'b00001;

    localparam logic [2:0] IDX_L  = 3'd4;
    localparam logic [2:0] IDX_R  = 3'd3;
    localparam logic [2:0] IDX_U  = 3'd2;
    localparam logic [2:0] IDX_D  = 3'd1;
    localparam logic [2:0] IDX_PE = 3'd0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Index (0..4) to one-hot; out-of-range indices give all zeros.
    function automatic logic [4:0] idx_to_onehot5(input logic [2:0] idx);
        logic [4:0] oh;
        oh = 5'b00000;
        case (idx)
            3'd0:    oh = 5'b00001;
            3'd1:    oh = 5'b00010;
            3'd2:    oh = 5'b00100;
            3'd3:    oh = 5'b01000;
            3'd4:    oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

    // True when exactly one bit of a 5-bit code is set.
    function automatic logic is_onehot5(input logic [4:0] v);
        int ones;
        ones = 0;
        for (int i = 0; i < 5; i++) begin
            ones = ones + int'(v[i]);
        end
        return (ones == 1);
    endfunction

endpackage

// File: rtl/output_arbiter_port_rr_arbiter5.sv
// rr_arbiter5: combinational 5-input round-robin arbiter.
//  Search starts at index ptr-1 and walks downward, wrapping from 0 to 4,
//  so the input that won last time has the lowest priority.
// Ports
//  req       in   5  request vector (already masked by the caller)
//  ptr       in   3  index of the last winner (0..4)
//  grant     out  5  one-hot grant, zero when no request
//  grant_idx out  3  index of the granted input (0 when no grant)
module rr_arbiter5
    import noc_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic [4:0] grant,
    output logic [2:0] grant_idx
);

    logic [2:0] ptr_s;
    logic [2:0] idx_s;
    logic       found_s;

    // A corrupted pointer (5..7) is treated as PE so the scan stays in range.
    assign ptr_s = (ptr > 3'd4) ? IDX_PE : ptr;

    // Rotating priority scan: first requester found below the pointer wins.
    always_comb begin
        found_s   = 1'b0;
        grant_idx = 3'd0;
        idx_s     = 3'd0;
        for (int i = 1; i <= 5; i++) begin
            idx_s = (ptr_s >= 3'(i)) ? (ptr_s - 3'(i)) : (ptr_s + 3'(5 - i));
            if (!found_s && req[idx_s]) begin
                found_s   = 1'b1;
                grant_idx = idx_s;
            end else begin
                found_s   = found_s;
            end
        end
        grant = found_s ? idx_to_onehot5(grant_idx) : 5'b00000;
    end

endmodule

// File: rtl/output_arbiter_port.sv
// output_arbiter_port: output stage of one router port.
//  Arbitrates the five input interfaces round-robin, captures the winning flit
//  into a 1-deep output register and hands it downstream on so/ro. The granted
//  input receives a same-cycle buf_clear pulse so it can free its buffer.
// Optional feature: define OUT_GRANT_CNT_EN to add per-input saturating grant
//  counters on the grant_cnt port.
// Ports
//  clk        in   1             clock
//  rst        in   1             asynchronous active-low reset
//  req_in     in   5             per-input request, index 4..0 = L,R,U,D,PE
//  data_in    in   5*DATA_WIDTH  input k flit at [k*DATA_WIDTH +: DATA_WIDTH]
//  buf_clear  out  5             one-hot pulse to the granted input
//  so         out  1             output register holds a valid flit
//  ro         in   1             downstream ready
//  datao      out  DATA_WIDTH    output flit (qualified by so)
//  grant_cnt  out  5*16          per-input grant counters (OUT_GRANT_CNT_EN only)
module output_arbiter_port
    import noc_pkg::*;
#(
    parameter int         DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [4:0] DIRECTION  = DIR_L,
    parameter logic [4:0] IN_MASK    = 5'b11111
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4:0]              req_in,
    input  logic [5*DATA_WIDTH-1:0] data_in,
    output logic [4:0]              buf_clear,
    output logic                    so,
    input  logic                    ro,
    output logic [DATA_WIDTH-1:0]   datao
`ifdef OUT_GRANT_CNT_EN
    ,
    output logic [NUM_IN*GCNT_W-1:0] grant_cnt
`endif
);

    // A malformed DIRECTION code disables every input instead of letting the
    // port forward traffic under an undefined identity.
    localparam logic [4:0] EFF_MASK = IN_MASK & {5{is_onehot5(DIRECTION)}};

    out_state_e            state_r;
    logic [2:0]            ptr_r;
    logic [DATA_WIDTH-1:0] datao_r;
    logic [4:0]            req_m_s;
    logic [4:0]            grant_s;
    logic [2:0]            grant_idx_s;
    logic                  cap_en_s;

    assign req_m_s  = req_in & EFF_MASK;
    assign so       = (state_r == ST_FULL);
    assign datao    = datao_r;
    // The output register can take a new flit when empty or draining this edge.
    assign cap_en_s = ~so | ro;
    // Gated by rst so no input frees its buffer while the port is held in reset.
    assign buf_clear = grant_s & {5{cap_en_s & rst}};

    rr_arbiter5 u_arb (
        .req       (req_m_s),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Output FSM: EMPTY/FULL state, round-robin pointer and the flit register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_EMPTY;
            ptr_r   <= IDX_PE;
            datao_r <= '0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (|grant_s) begin
                        datao_r <= data_in[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
                        ptr_r   <= grant_idx_s;
                        state_r <= ST_FULL;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (ro) begin
                        // Drain and refill on the same edge keeps 1 flit/clock.
                        if (|grant_s) begin
                            datao_r <= data_in[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
                            ptr_r   <= grant_idx_s;
                            state_r <= ST_FULL;
                        end else begin
                            state_r <= ST_EMPTY;
                        end
                    end else begin
                        state_r <= ST_FULL;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef OUT_GRANT_CNT_EN
    logic [GCNT_W-1:0] cnt_r [NUM_IN];

    // Per-input grant counters, saturating at all ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_IN; k++) begin
                cnt_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (buf_clear[k] && (cnt_r[k] != {GCNT_W{1'b1}})) begin
                    cnt_r[k] <= cnt_r[k] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt_out
        assign grant_cnt[g*GCNT_W +: GCNT_W] = cnt_r[g];
    end
`endif

endmodule

// File: tb/tb_output_arbiter_port.sv
// Self-checking bench for output_arbiter_port.
//  Two instances: full mask and IN_MASK=5'b11011 (U input disabled).
//  A directed vector table covers single request, fairness and backpressure;
//  hand-written sequences cover reset and masking; a random phase compares
//  both instances against a transaction-level reference model.
module tb_output_arbiter_port;

    logic         clk;
    logic         rst;
    logic [4:0]   req_in;
    logic [319:0] data_in;
    logic         ro;
    logic [4:0]   buf_clear, bc_m;
    logic         so, so_m;
    logic [63:0]  datao, datao_m;
`ifdef OUT_GRANT_CNT_EN
    logic [79:0]  grant_cnt, grant_cnt_m;
`endif

    int vectors     = 0;
    int miscompares = 0;

    output_arbiter_port #(.DATA_WIDTH(64), .DIRECTION(5'b10000), .IN_MASK(5'b11111)) u_dut (
        .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in),
        .buf_clear(buf_clear), .so(so), .ro(ro), .datao(datao)
`ifdef OUT_GRANT_CNT_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    output_arbiter_port #(.DATA_WIDTH(64), .DIRECTION(5'b01000), .IN_MASK(5'b11011)) u_dut_m (
        .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in),
        .buf_clear(bc_m), .so(so_m), .ro(ro), .datao(datao_m)
`ifdef OUT_GRANT_CNT_EN
        , .grant_cnt(grant_cnt_m)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one record per instance
    logic [4:0]  m_mask [2];
    bit          m_valid [2];
    logic [63:0] m_hold [2];
    int          m_ptr [2];
    int          m_cnt [2][5];

    typedef struct {
        logic [4:0]  req;
        logic        ro;
        logic [4:0]  exp_bc;
        logic        exp_so;
        logic [63:0] exp_datao;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner: first requester found scanning from ptr-1 downward with wrap.
    function automatic int mwin(input logic [4:0] r, input int p);
        for (int k = 1; k <= 5; k++) begin
            int idx;
            idx = (p - k + 5) % 5;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_hold[d]  = 64'h0;
            m_ptr[d]   = 0;
            for (int k = 0; k < 5; k++) m_cnt[d][k] = 0;
        end
    endtask

    function automatic logic [4:0] model_bc(input int d);
        int w;
        w = mwin(req_in & m_mask[d], m_ptr[d]);
        if (!rst || w < 0 || !(!m_valid[d] || ro)) return 5'b00000;
        return 5'(1 << w);
    endfunction

    // Compare both instances against the model (inputs already applied).
    task automatic model_check();
        if (!rst) model_reset();
        chk("bc", {59'h0, buf_clear}, {59'h0, model_bc(0)});
        chk("so", {63'h0, so}, {63'h0, m_valid[0]});
        chk("datao", datao, m_hold[0]);
        chk("bc_mask", {59'h0, bc_m}, {59'h0, model_bc(1)});
        chk("so_mask", {63'h0, so_m}, {63'h0, m_valid[1]});
        chk("datao_mask", datao_m, m_hold[1]);
`ifdef OUT_GRANT_CNT_EN
        for (int k = 0; k < 5; k++) begin
            chk("gcnt", {48'h0, grant_cnt[k*16 +: 16]}, 64'(m_cnt[0][k]));
        end
`endif
    endtask

    // Advance the model by one edge using the current inputs, then clock.
    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            int w;
            if (!rst) begin
                m_valid[d] = 1'b0;
                m_hold[d]  = 64'h0;
                m_ptr[d]   = 0;
                for (int k = 0; k < 5; k++) m_cnt[d][k] = 0;
            end else if (!m_valid[d] || ro) begin
                w = mwin(req_in & m_mask[d], m_ptr[d]);
                if (w >= 0) begin
                    m_valid[d] = 1'b1;
                    m_hold[d]  = data_in[w*64 +: 64];
                    m_ptr[d]   = w;
                    if (m_cnt[d][w] < 65535) m_cnt[d][w]++;
                end else begin
                    m_valid[d] = 1'b0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] r, input logic o);
        req_in = r;
        ro     = o;
        #2;
    endtask

    task automatic fixed_data();
        for (int k = 0; k < 5; k++) data_in[k*64 +: 64] = 64'(k) * 64'h100 + 64'hA5;
    endtask

    vec_t tbl [21];

    initial begin
        m_mask[0] = 5'b11111;
        m_mask[1] = 5'b11011;
        model_reset();
        rst     = 1'b0;
        req_in  = 5'b11111;
        ro      = 1'b1;
        data_in = '0;
        fixed_data();

        // Reset held with all inputs requesting: nothing may move.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(5'b11111, 1'b1);
            model_check();
            tick();
        end
        rst = 1'b1;

        // Directed table: single PE request, fairness, backpressure.
        tbl[0]  = '{5'b00001, 1'b1, 5'b00001, 1'b0, 64'h0};
        tbl[1]  = '{5'b00000, 1'b1, 5'b00000, 1'b1, 64'hA5};
        tbl[2]  = '{5'b00000, 1'b1, 5'b00000, 1'b0, 64'hA5};
        tbl[3]  = '{5'b11111, 1'b1, 5'b10000, 1'b0, 64'hA5};
        tbl[4]  = '{5'b11111, 1'b1, 5'b01000, 1'b1, 64'h4A5};
        tbl[5]  = '{5'b11111, 1'b1, 5'b00100, 1'b1, 64'h3A5};
        tbl[6]  = '{5'b11111, 1'b1, 5'b00010, 1'b1, 64'h2A5};
        tbl[7]  = '{5'b11111, 1'b1, 5'b00001, 1'b1, 64'h1A5};
        tbl[8]  = '{5'b11111, 1'b1, 5'b10000, 1'b1, 64'hA5};
        tbl[9]  = '{5'b11111, 1'b1, 5'b01000, 1'b1, 64'h4A5};
        tbl[10] = '{5'b11111, 1'b1, 5'b00100, 1'b1, 64'h3A5};
        tbl[11] = '{5'b11111, 1'b1, 5'b00010, 1'b1, 64'h2A5};
        tbl[12] = '{5'b11111, 1'b1, 5'b00001, 1'b1, 64'h1A5};
        for (int i = 13; i < 18; i++) tbl[i] = '{5'b01000, 1'b0, 5'b00000, 1'b1, 64'hA5};
        tbl[18] = '{5'b01000, 1'b1, 5'b01000, 1'b1, 64'hA5};
        tbl[19] = '{5'b00000, 1'b1, 5'b00000, 1'b1, 64'h3A5};
        tbl[20] = '{5'b00000, 1'b0, 5'b00000, 1'b0, 64'h3A5};
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].req, tbl[i].ro);
            chk($sformatf("tbl%0d_bc", i), {59'h0, buf_clear}, {59'h0, tbl[i].exp_bc});
            chk($sformatf("tbl%0d_so", i), {63'h0, so}, {63'h0, tbl[i].exp_so});
            chk($sformatf("tbl%0d_datao", i), datao, tbl[i].exp_datao);
            tick();
        end

        // Masked input: U request alone never reaches the 11011 instance.
        rst = 1'b0;
        #1;
        model_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(5'b00100, 1'b1);
            chk("mask_bc", {59'h0, bc_m}, 64'h0);
            chk("mask_so", {63'h0, so_m}, 64'h0);
            chk("unmasked_bc", {59'h0, buf_clear}, 64'h4);
            tick();
        end

        // Random traffic with occasional mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 149) == 0) rst = 1'b0;
            for (int k = 0; k < 5; k++) data_in[k*64 +: 64] = {$urandom, $urandom};
            drive(5'($urandom_range(0, 31)), ($urandom_range(0, 9) < 7));
            model_check();
            tick();
        end

`ifdef OUT_GRANT_CNT_EN
        // Counter saturation on L, then reset clears everything.
        rst = 1'b0;
        #1;
        model_reset();
        rst = 1'b1;
        fixed_data();
        for (int i = 0; i < 65534; i++) begin
            drive(5'b10000, 1'b1);
            tick();
        end
        chk("gcnt_L_fffe", {48'h0, grant_cnt[4*16 +: 16]}, 64'hFFFE);
        for (int i = 0; i < 3; i++) begin
            drive(5'b10000, 1'b1);
            tick();
            chk("gcnt_L_sat", {48'h0, grant_cnt[4*16 +: 16]}, 64'hFFFF);
        end
        rst = 1'b0;
        #1;
        chk("gcnt_reset", {48'h0, grant_cnt}, 64'h0);
        chk("so_reset", {63'h0, so}, 64'h0);
        tick();
        rst = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
